// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the 8-bit ALU: buffers tagged commands in a FIFO,
// issues them one at a time and returns the registered ALU result with its tag.
module alu_cmd_driver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_opcode_i,
    input  logic [7:0]       cmd_op1_i,
    input  logic [7:0]       cmd_op2_i,
    input  logic [TAG_W-1:0] cmd_tag_i,
    output logic [2:0]       alu_opcode_o,
    output logic [7:0]       alu_op1_o,
    output logic [7:0]       alu_op2_o,
    input  logic [15:0]      alu_result_i,
    input  logic             alu_flag_c_i,
    input  logic             alu_flag_z_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_result_o,
    output logic             rsp_flag_c_o,
    output logic             rsp_flag_z_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [7:0]       op1;
        logic [7:0]       op2;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_e;

    cmd_t             mem_q [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, busy_d;
    state_e           state_q;
    logic [TAG_W-1:0] tag_q;
    logic             cmd_ready_q, busy_q, rsp_valid_q, rsp_flag_c_q, rsp_flag_z_q;
    logic [2:0]       alu_opcode_q;
    logic [7:0]       alu_op1_q, alu_op2_q;
    logic [15:0]      rsp_result_q;
    logic [TAG_W-1:0] rsp_tag_q;

    // FIFO occupancy and busy look-ahead so both outputs can be registered
    always_comb begin
        push    = cmd_valid_i && cmd_ready_q;
        pop     = (state_q == IDLE) && (count_q != '0);
        head    = mem_q[rd_ptr_q];
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        busy_d = (count_d != '0) || pop || (state_q == DRIVE) || (state_q == SAMPLE)
                 || ((state_q == RESP) && !rsp_ready_i);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_t'{opcode: cmd_opcode_i, op1: cmd_op1_i,
                                      op2: cmd_op2_i, tag: cmd_tag_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
            tag_q        <= '0;
            alu_opcode_q <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flag_c_q <= 1'b0;
            rsp_flag_z_q <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            count_q     <= count_d;
            cmd_ready_q <= (count_d != CNT_W'(DEPTH));
            busy_q      <= busy_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        alu_opcode_q <= head.opcode;
                        alu_op1_q    <= head.op1;
                        alu_op2_q    <= head.op2;
                        tag_q        <= head.tag;
                        state_q      <= DRIVE;
                    end
                end
                DRIVE: state_q <= SAMPLE;
                // ALU registered its result at the DRIVE closing edge
                SAMPLE: begin
                    rsp_result_q <= alu_result_i;
                    rsp_flag_c_q <= alu_flag_c_i;
                    rsp_flag_z_q <= alu_flag_z_i;
                    rsp_tag_q    <= tag_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign busy_o       = busy_q;
    assign alu_opcode_o = alu_opcode_q;
    assign alu_op1_o    = alu_op1_q;
    assign alu_op2_o    = alu_op2_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_flag_c_o = rsp_flag_c_q;
    assign rsp_flag_z_o = rsp_flag_z_q;
    assign rsp_tag_o    = rsp_tag_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: behavioural ALU stub, response scoreboard,
// directed scenarios and a randomized stream with random response backpressure.
module tb_alu_cmd_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode = '0;
    logic [7:0]  cmd_op1 = '0, cmd_op2 = '0;
    logic [3:0]  cmd_tag = '0;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_op1, alu_op2;
    logic [15:0] alu_result;
    logic        alu_c, alu_z;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_result;
    logic        rsp_c, rsp_z;
    logic [3:0]  rsp_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        z;
        logic [3:0]  tag;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t obs_q[$];
    logic c_model = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.DEPTH(4), .TAG_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_opcode_i(cmd_opcode), .cmd_op1_i(cmd_op1), .cmd_op2_i(cmd_op2), .cmd_tag_i(cmd_tag),
        .alu_opcode_o(alu_opcode), .alu_op1_o(alu_op1), .alu_op2_o(alu_op2),
        .alu_result_i(alu_result), .alu_flag_c_i(alu_c), .alu_flag_z_i(alu_z),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_flag_c_o(rsp_c), .rsp_flag_z_o(rsp_z),
        .rsp_tag_o(rsp_tag), .busy_o(busy)
    );

    // {carry/borrow, result}; carry only meaningful for ADD and SUB
    function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; return {s[8], 7'h00, s}; end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; return {s[8], 8'h00, s[7:0]}; end
            3'd2: return {1'b0, 16'(a) * 16'(b)};
            3'd3: return {9'h000, a & b};
            3'd4: return {9'h000, a | b};
            3'd5: return {9'h000, ~(a & b)};
            3'd6: return {9'h000, ~(a | b)};
            default: return {9'h000, a ^ b};
        endcase
    endfunction

    // ALU stub: one-clock registered, no reset, flagC kept for non-arithmetic ops
    always @(posedge clk) begin
        logic [16:0] r;
        r = alu_fn(alu_opcode, alu_op1, alu_op2);
        alu_result <= r[15:0];
        alu_z      <= (r[15:0] == 16'h0000);
        if (alu_opcode == 3'd0 || alu_opcode == 3'd1) alu_c <= r[16];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        logic [16:0] r;
        rsp_t e;
        r = alu_fn(op, a, b);
        if (op == 3'd0 || op == 3'd1) c_model = r[16];
        e.res = r[15:0];
        e.c   = c_model;
        e.z   = (r[15:0] == 16'h0000);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        logic acc;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_op1 = a; cmd_op2 = b; cmd_tag = tag;
        for (int i = 0; i < 200; i++) begin
            acc = cmd_ready;
            tick();
            if (acc) begin
                push_exp(op, a, b, tag);
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 200; i++) begin
            if (!busy) return;
            tick();
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Response monitor: handshake compare against model, stability while stalled
    logic held = 1'b0;
    rsp_t saved;
    always @(negedge clk) begin
        rsp_t o, e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_result", 32'(rsp_result), 32'(saved.res));
                chk("hold_c", 32'(rsp_c), 32'(saved.c));
                chk("hold_z", 32'(rsp_z), 32'(saved.z));
                chk("hold_tag", 32'(rsp_tag), 32'(saved.tag));
            end
            o.res = rsp_result; o.c = rsp_c; o.z = rsp_z; o.tag = rsp_tag;
            if (rsp_valid && rsp_ready) begin
                obs_q.push_back(o);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_result", 32'(o.res), 32'(e.res));
                    chk("rsp_c", 32'(o.c), 32'(e.c));
                    chk("rsp_z", 32'(o.z), 32'(e.z));
                    chk("rsp_tag", 32'(o.tag), 32'(e.tag));
                end
                held = 1'b0;
            end else if (rsp_valid) begin
                held  = 1'b1;
                saved = o;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int accepted;
        logic acc;
        logic [3:0] next_tag;
        logic [2:0] op;
        logic [7:0] a, b;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu", {13'h0, alu_opcode, alu_op1, alu_op2}, 32'd0);
        chk("rst_rsp", {11'h0, rsp_result, rsp_c, rsp_z, rsp_tag}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // ADD 200+100 with latency profile
        obs_q.delete();
        send(3'd0, 8'd200, 8'd100, 4'd3);
        chk("lat_e0", 32'(rsp_valid), 32'd0);
        chk("busy_e0", 32'(busy), 32'd1);
        tick();
        chk("lat_e1", 32'(rsp_valid), 32'd0);
        chk("alu_issue", {13'h0, alu_opcode, alu_op1, alu_op2}, {13'h0, 3'd0, 8'd200, 8'd100});
        tick();
        chk("lat_e2", 32'(rsp_valid), 32'd0);
        tick();
        chk("lat_e3", 32'(rsp_valid), 32'd1);
        chk("add_result", 32'(rsp_result), 32'h012C);
        chk("add_flags", {30'h0, rsp_c, rsp_z}, 32'b10);
        chk("add_tag", 32'(rsp_tag), 32'd3);
        wait_idle();
        chk("alu_hold", {13'h0, alu_opcode, alu_op1, alu_op2}, {13'h0, 3'd0, 8'd200, 8'd100});

        // SUB 5-5 then MUL 255*255
        obs_q.delete();
        send(3'd1, 8'd5, 8'd5, 4'd1);
        send(3'd2, 8'd255, 8'd255, 4'd2);
        wait_idle();
        chk("sub_mul_count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            chk("sub_result", 32'(obs_q[0].res), 32'h0000);
            chk("sub_flags", {30'h0, obs_q[0].c, obs_q[0].z}, 32'b01);
            chk("mul_result", 32'(obs_q[1].res), 32'hFE01);
            chk("mul_flags", {30'h0, obs_q[1].c, obs_q[1].z}, 32'b00);
            chk("mul_order", 32'(obs_q[1].tag), 32'd2);
        end

        // Backpressure: DEPTH+1 accepts, then stall and drain in order
        obs_q.delete();
        rsp_ready = 1'b0;
        accepted  = 0;
        next_tag  = 4'd1;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
            cmd_valid = 1'b1; cmd_opcode = op; cmd_op1 = a; cmd_op2 = b; cmd_tag = next_tag;
            acc = cmd_ready;
            tick();
            if (acc) begin
                push_exp(op, a, b, next_tag);
                next_tag = next_tag + 4'd1;
                accepted++;
            end
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", 32'(accepted), 32'd5);
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (20) tick();
        chk("bp_no_rsp", 32'(obs_q.size()), 32'd0);
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        wait_idle();
        chk("bp_rsp_count", 32'(obs_q.size()), 32'd5);
        for (int i = 0; i < obs_q.size(); i++) chk("bp_tag_order", 32'(obs_q[i].tag), 32'(i + 1));
        chk("bp_busy_end", 32'(busy), 32'd0);

        // ADD 255+1 then AND: carry held over
        obs_q.delete();
        send(3'd0, 8'd255, 8'd1, 4'd7);
        send(3'd3, 8'hF0, 8'h0F, 4'd8);
        wait_idle();
        chk("carry_count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            chk("add255_result", 32'(obs_q[0].res), 32'h0100);
            chk("add255_flags", {30'h0, obs_q[0].c, obs_q[0].z}, 32'b10);
            chk("and_result", 32'(obs_q[1].res), 32'h0000);
            chk("and_flags", {30'h0, obs_q[1].c, obs_q[1].z}, 32'b11);
        end

        // Reset while in SAMPLE with two queued
        obs_q.delete();
        send(3'd0, 8'd10, 8'd20, 4'd9);
        send(3'd0, 8'd30, 8'd40, 4'd10);
        send(3'd0, 8'd50, 8'd60, 4'd11);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        c_model = 1'b0;
        #1;
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_alu", {13'h0, alu_opcode, alu_op1, alu_op2}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("dropped_no_rsp", 32'(obs_q.size()), 32'd0);
        chk("dropped_idle", 32'(busy), 32'd0);
        send(3'd0, 8'd1, 8'd1, 4'd5);
        wait_idle();
        chk("post_rst_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() == 1) chk("post_rst_result", 32'(obs_q[0].res), 32'h0002);

        // Randomized stream with random backpressure
        for (int i = 0; i < 400; i++) begin
            rsp_ready  = ($urandom_range(0, 3) != 0);
            cmd_valid  = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
            cmd_opcode = op; cmd_op1 = a; cmd_op2 = b; cmd_tag = 4'($urandom);
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) push_exp(op, a, b, cmd_tag);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
